// File: rtl/rv_regfile_alu_imm_if.sv
// rv_regfile_alu_imm_if: instruction/control inputs and datapath outputs of the execute core
interface rv_regfile_alu_imm_if;
  logic [31:0] instr;
  logic        regRW;
  logic [31:0] wdata;
  logic        ALUsrc;
  logic [1:0]  immsrc;
  logic [4:0]  ALUop;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic [3:0]  status;
  modport master (
    output instr, regRW, wdata, ALUsrc, immsrc, ALUop,
    input  rdata1, rdata2, imm, alu_out, status
  );
  modport slave (
    input  instr, regRW, wdata, ALUsrc, immsrc, ALUop,
    output rdata1, rdata2, imm, alu_out, status
  );
endinterface

// File: rtl/rv_regfile_alu_imm.sv
// rv_regfile_alu_imm: RV32 register file, immediate generator and ALU with N/Z/C/V flags
module rv_regfile_alu_imm #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic clk,
  input logic rst,
  rv_regfile_alu_imm_if.slave bus
);
  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [4:0] rd, rs1, rs2;
  logic [XLEN-1:0] a, rdata2, imm, b, res;
  logic [XLEN:0] sum, diff;
  logic c, v;
  logic unused_opcode;
  assign rd  = bus.instr[11:7];
  assign rs1 = bus.instr[19:15];
  assign rs2 = bus.instr[24:20];
  assign unused_opcode = ^bus.instr[6:0];
  // next register state: write rd unless it is x0
  always_comb begin
    regs_d = regs_q;
    if (bus.regRW && rd != 5'd0) regs_d[rd] = bus.wdata;
  end
  // register array; reset wins over a simultaneous write
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end
  // combinational reads see the pre-edge value; x0 is hardwired to zero
  always_comb begin
    a      = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    rdata2 = (rs2 == 5'd0) ? '0 : regs_q[rs2];
  end
  // immediate formats, all sign-extended from instr[31]
  always_comb begin
    imm = (bus.immsrc == 2'b00) ? {{20{bus.instr[31]}}, bus.instr[31:20]} :
          (bus.immsrc == 2'b01) ? {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]} :
          (bus.immsrc == 2'b10) ? {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                                   bus.instr[30:25], bus.instr[11:8], 1'b0} :
                                  {bus.instr[31:12], 12'b0};
  end
  // ALU; carry/overflow only meaningful for ADD and SUB
  always_comb begin
    b    = bus.ALUsrc ? rdata2 : imm;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    res  = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (bus.ALUop)
      5'd0: begin
        res = sum[XLEN-1:0];
        c   = sum[XLEN];
        v   = (a[31] == b[31]) && (res[31] != a[31]);
      end
      5'd1: begin
        res = diff[XLEN-1:0];
        c   = ~diff[XLEN];
        v   = (a[31] != b[31]) && (res[31] != a[31]);
      end
      5'd2:    res = a & b;
      5'd3:    res = a | b;
      5'd4:    res = a ^ b;
      5'd5:    res = a << b[4:0];
      5'd6:    res = a >> b[4:0];
      5'd7:    res = $signed(a) >>> b[4:0];
      5'd8:    res = {31'b0, $signed(a) < $signed(b)};
      5'd9:    res = {31'b0, a < b};
      5'd10:   res = b;
      default: res = '0;
    endcase
  end
  // drive the bus outputs
  always_comb begin
    bus.rdata1  = a;
    bus.rdata2  = rdata2;
    bus.imm     = imm;
    bus.alu_out = res;
    bus.status  = {res[31], res == '0, c, v};
  end
endmodule

// File: tb/tb_rv_regfile_alu_imm.sv
// tb_rv_regfile_alu_imm: directed table-driven checks of register file, immediates and ALU
module tb_rv_regfile_alu_imm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int passed = 0;
  rv_regfile_alu_imm_if bus ();
  rv_regfile_alu_imm dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  op;
    logic [31:0] exp;
    logic [3:0]  st;
  } vec_t;
  vec_t vecs[16];
  function automatic logic [31:0] rr(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    return {7'b0, s2, s1, 3'b0, d, 7'b0110011};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic wr(input logic [4:0] d, input logic [31:0] data);
    @(negedge clk);
    bus.instr = rr(5'd0, 5'd0, d);
    bus.wdata = data;
    bus.regRW = 1'b1;
    @(posedge clk);
    #1 bus.regRW = 1'b0;
  endtask
  initial begin
    vecs[0]  = '{5'd1, 5'd2, 5'd0,  32'h80000000, 4'b1001};
    vecs[1]  = '{5'd3, 5'd3, 5'd1,  32'h00000000, 4'b0110};
    vecs[2]  = '{5'd0, 5'd2, 5'd1,  32'hFFFFFFFF, 4'b1000};
    vecs[3]  = '{5'd4, 5'd7, 5'd7,  32'hF8000000, 4'b1000};
    vecs[4]  = '{5'd4, 5'd7, 5'd6,  32'h08000000, 4'b0000};
    vecs[5]  = '{5'd6, 5'd2, 5'd8,  32'h00000001, 4'b0000};
    vecs[6]  = '{5'd6, 5'd2, 5'd9,  32'h00000000, 4'b0100};
    vecs[7]  = '{5'd1, 5'd2, 5'd31, 32'h00000000, 4'b0100};
    vecs[8]  = '{5'd6, 5'd1, 5'd2,  32'h7FFFFFFF, 4'b0000};
    vecs[9]  = '{5'd4, 5'd2, 5'd3,  32'h80000001, 4'b1000};
    vecs[10] = '{5'd6, 5'd6, 5'd4,  32'h00000000, 4'b0100};
    vecs[11] = '{5'd2, 5'd7, 5'd5,  32'h00000010, 4'b0000};
    vecs[12] = '{5'd0, 5'd3, 5'd10, 32'h00000005, 4'b0000};
    vecs[13] = '{5'd6, 5'd2, 5'd0,  32'h00000000, 4'b0110};
    vecs[14] = '{5'd2, 5'd6, 5'd1,  32'h00000002, 4'b0000};
    vecs[15] = '{5'd4, 5'd2, 5'd1,  32'h7FFFFFFF, 4'b0011};
    bus.instr = '0; bus.regRW = 1'b0; bus.wdata = '0;
    bus.ALUsrc = 1'b1; bus.immsrc = 2'b00; bus.ALUop = 5'd0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.instr = rr(5'd5, 5'd31, 5'd0); #1;
    check("rst_rs1_x5", bus.rdata1, 32'h0);
    check("rst_rs2_x31", bus.rdata2, 32'h0);
    bus.instr = rr(5'd1, 5'd17, 5'd0); #1;
    check("rst_rs1_x1", bus.rdata1, 32'h0);
    check("rst_rs2_x17", bus.rdata2, 32'h0);
    @(negedge clk);
    bus.instr = rr(5'd5, 5'd0, 5'd5);
    bus.wdata = 32'h12345678;
    bus.regRW = 1'b1; #1;
    check("wr_before_edge", bus.rdata1, 32'h0);
    @(posedge clk); #1 bus.regRW = 1'b0; #1;
    check("wr_after_edge", bus.rdata1, 32'h12345678);
    wr(5'd0, 32'hDEADBEEF);
    bus.instr = rr(5'd0, 5'd0, 5'd0); #1;
    check("x0_rs1", bus.rdata1, 32'h0);
    check("x0_rs2", bus.rdata2, 32'h0);
    @(negedge clk);
    bus.instr = rr(5'd5, 5'd5, 5'd5);
    bus.wdata = 32'hCAFEF00D;
    bus.regRW = 1'b1; rst = 1'b1;
    @(posedge clk); #1 bus.regRW = 1'b0; rst = 1'b0; #1;
    check("rst_beats_write", bus.rdata1, 32'h0);
    wr(5'd1, 32'h7FFFFFFF);
    wr(5'd2, 32'h00000001);
    wr(5'd3, 32'h00000005);
    wr(5'd4, 32'h80000000);
    wr(5'd6, 32'hFFFFFFFF);
    wr(5'd7, 32'h00000004);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.instr = rr(vecs[i].s1, vecs[i].s2, 5'd0);
      bus.ALUsrc = 1'b1;
      bus.ALUop = vecs[i].op; #1;
      check($sformatf("alu_out[%0d]", i), bus.alu_out, vecs[i].exp);
      check($sformatf("status[%0d]", i), {28'b0, bus.status}, {28'b0, vecs[i].st});
    end
    @(negedge clk);
    bus.ALUsrc = 1'b0; bus.ALUop = 5'd0;
    bus.instr = 32'hFFF00093; bus.immsrc = 2'b00; #1;
    check("imm_i", bus.imm, 32'hFFFFFFFF);
    check("addi_out", bus.alu_out, 32'hFFFFFFFF);
    check("addi_status", {28'b0, bus.status}, 32'h8);
    bus.instr = 32'h80000080; bus.immsrc = 2'b01; #1;
    check("imm_s", bus.imm, 32'hFFFFF801);
    bus.instr = 32'hFE000EE3; bus.immsrc = 2'b10; #1;
    check("imm_b", bus.imm, 32'hFFFFFFFC);
    bus.instr = 32'h12345037; bus.immsrc = 2'b11; bus.ALUop = 5'd10; #1;
    check("imm_u", bus.imm, 32'h12345000);
    check("lui_out", bus.alu_out, 32'h12345000);
    check("lui_status", {28'b0, bus.status}, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
